wishbone_rr_arbiter: RTL and testbench
======================================

# wishbone_rr_arbiter

Round-robin Wishbone bus arbiter that lets 2^MASTERS_WIDTH bus masters share one slave port. It sits between the masters (ModbusToWishbone, Processor) and the address-decoded slave mux (progmem, regmem, ports). Ownership is locked for the whole of a master's CYC assertion. A watchdog terminates any strobe the slave leaves unacknowledged, so a missing slave cannot hang the bus.

## Interface
- MASTERS_WIDTH, 1, log2 of master count; N = 1 << MASTERS_WIDTH.
- ADDRESS_WIDTH, 16, Wishbone address width.
- DATA_WIDTH, 16, Wishbone data width.
- TIMEOUT_CYCLES, 255, wait-state limit before error termination; 0 disables the watchdog; must fit in 16 bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- mCycI  input  N  per-master CYC.
- mStbI  input  N  per-master STB.
- mWeI  input  N  per-master WE.
- mAdrIPacked  input  N*ADDRESS_WIDTH  master i occupies bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- mDatIPacked  input  N*DATA_WIDTH  master write data, same packing.
- mDatOPacked  output  N*DATA_WIDTH  read data; every lane = sDatI.
- mAckO  output  N  ACK, routed to the owner only.
- mErrO  output  N  timeout ERR, routed to the owner only.
- grant  output  N  one-hot current owner; all zero when idle.
- sCycO, sStbO, sWeO  output  1 each  slave-side controls.
- sAdrO  output  ADDRESS_WIDTH  slave address.
- sDatO  output  DATA_WIDTH  slave write data.
- sAckI  input  1  slave ACK.
- sDatI  input  DATA_WIDTH  slave read data.

## Operation
- State: valid (1 bit), owner (MASTERS_WIDTH bits), last (MASTERS_WIDTH bits), wait counter (16 bits).
- Reset (rst=0 at an edge): valid=0, owner=0, last=N-1, counter=0. Master 0 therefore wins first.
- States:
  - IDLE (valid=0).
  - OWNED (valid=1).
- Arbitration is evaluated on each edge where the state is IDLE, or OWNED with mCycI[owner]=0.
- Winner is the first i with mCycI[i]=1, searching last+1, last+2, … modulo N.
  - If a winner exists: owner←i, last←i, valid←1.
  - If none: valid←0.
- OWNED with mCycI[owner]=1: owner is held regardless of other requests (cycle lock).
- Slave-side outputs are combinational from the owner when valid=1:
  - sCycO = mCycI[owner]
  - sStbO = mStbI[owner]
  - sWeO = mWeI[owner]
  - sAdrO and sDatO = the owner's lane
- When valid=0: sCycO, sStbO, sWeO = 0; sAdrO, sDatO = 0.
- mAckO[owner] = valid & sCycO & sStbO & sAckI; all other bits are 0.
- Watchdog, when TIMEOUT_CYCLES ≠ 0:
  - Counter increments on each edge with sStbO=1 and sAckI=0.
  - Counter clears on each edge with sAckI=1 or sStbO=0.
  - When counter == TIMEOUT_CYCLES and sAckI=0: mErrO[owner]=1 combinationally for that cycle, and the counter clears at the next edge.
  - mAckO and mErrO are never both 1.
- A late sAckI in the same cycle as the timeout wins: ACK is given, ERR is not.

## Timing
- Grant latency: mCycI[i] rising at cycle k while IDLE → grant[i] and slave signals valid in cycle k+1.
- Handoff: owner drops CYC in cycle k while another master requests → new grant in cycle k+1, with no dead cycle.
- Classic single-cycle Wishbone: a slave with combinational ACK completes a strobe in the cycle it is presented.
- Timeout: strobe presented in cycle k with no ACK → mErrO pulse in cycle k+TIMEOUT_CYCLES (1 cycle wide).
- Owner dropping CYC mid-strobe: the slave sees sCycO=0 immediately (combinational). The counter clears at the next edge.
- Simultaneous requests from all masters while IDLE: the lowest index after last wins. Strict rotation thereafter, so no master is granted twice while another master waits.
- rst=0 while OWNED: takes effect at that edge. The bus returns to IDLE and all outputs go to 0 in the next cycle, regardless of in-flight transfers.
- Outputs during and immediately after reset: grant=0, mAckO=0, mErrO=0, sCycO=sStbO=sWeO=0, sAdrO=0, sDatO=0.

## Test plan
- Single master, N=2: master 1 raises CYC+STB, adr=16'h4010, we=1, dat=16'h00A5, slave ACKs immediately.
  - Expected: grant=2'b10 one cycle later; sAdrO=16'h4010, sDatO=16'h00A5; mAckO=2'b10; mAckO[0] never 1.
- Contention: both masters raise CYC in the same cycle out of reset.
  - Expected: master 0 granted first. On its CYC drop, master 1 is granted the next cycle. With both still requesting, grants alternate 0,1,0,1 across four transactions.
- Cycle lock: master 0 holds CYC for 3 back-to-back strobes while master 1 requests.
  - Expected: grant stays 2'b01 for all 3 ACKs; grant goes to 2'b10 one cycle after master 0 drops CYC.
- Timeout: TIMEOUT_CYCLES=4, slave never ACKs.
  - Expected: mErrO[owner]=1 exactly 4 cycles after the strobe starts, for 1 cycle.
  - Second check: slave ACKs at wait cycle 4 → mAckO=1, mErrO=0.
- Reset mid-transfer: assert rst=0 while master 1 owns the bus with STB high.
  - Expected: next cycle grant=0, sCycO=0, mAckO=0. After release, master 0 wins a simultaneous request.
- Read data: slave drives sDatI=16'h00A5 with ACK to master 1.
  - Expected: both lanes of mDatOPacked = 16'h00A5; only mAckO[1]=1.

Source files
------------

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave port, ownership
// locked for the whole CYC, with a watchdog that errors out unacked strobes.
module wishbone_rr_arbiter #(
    parameter int MASTERS_WIDTH  = 1,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [(1<<MASTERS_WIDTH)-1:0]            mCycI,
    input  logic [(1<<MASTERS_WIDTH)-1:0]            mStbI,
    input  logic [(1<<MASTERS_WIDTH)-1:0]            mWeI,
    input  logic [(1<<MASTERS_WIDTH)*ADDRESS_WIDTH-1:0] mAdrIPacked,
    input  logic [(1<<MASTERS_WIDTH)*DATA_WIDTH-1:0] mDatIPacked,
    output logic [(1<<MASTERS_WIDTH)*DATA_WIDTH-1:0] mDatOPacked,
    output logic [(1<<MASTERS_WIDTH)-1:0]            mAckO,
    output logic [(1<<MASTERS_WIDTH)-1:0]            mErrO,
    output logic [(1<<MASTERS_WIDTH)-1:0]            grant,
    output logic                                     sCycO,
    output logic                                     sStbO,
    output logic                                     sWeO,
    output logic [ADDRESS_WIDTH-1:0]                 sAdrO,
    output logic [DATA_WIDTH-1:0]                    sDatO,
    input  logic                                     sAckI,
    input  logic [DATA_WIDTH-1:0]                    sDatI
);

    localparam int N = 1 << MASTERS_WIDTH;
    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    logic                     valid_q, valid_d;
    logic [MASTERS_WIDTH-1:0] owner_q, owner_d;
    logic [MASTERS_WIDTH-1:0] last_q, last_d;
    logic [15:0]              cnt_q, cnt_d;

    logic                     active;
    logic                     ack;
    logic                     timeout;
    logic                     found;
    logic [MASTERS_WIDTH-1:0] idx;

    assign mDatOPacked = {N{sDatI}};

    // Outputs are forced idle while reset is held, not just after it.
    always_comb begin
        active = valid_q & rst;
        sCycO  = 1'b0;
        sStbO  = 1'b0;
        sWeO   = 1'b0;
        sAdrO  = '0;
        sDatO  = '0;
        if (active) begin
            sCycO = mCycI[owner_q];
            sStbO = mStbI[owner_q];
            sWeO  = mWeI[owner_q];
            sAdrO = mAdrIPacked[int'(owner_q)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            sDatO = mDatIPacked[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
        end
        ack     = active & sCycO & sStbO & sAckI;
        timeout = (TMO != 16'd0) & active & sStbO & ~sAckI & (cnt_q == TMO);
        mAckO   = '0;
        mErrO   = '0;
        grant   = '0;
        mAckO[owner_q] = ack;
        mErrO[owner_q] = timeout;
        grant[owner_q] = active;
    end

    always_comb begin
        valid_d = valid_q;
        owner_d = owner_q;
        last_d  = last_q;
        found   = 1'b0;
        idx     = last_q;
        if (!valid_q || !mCycI[owner_q]) begin
            valid_d = 1'b0;
            for (int k = 1; k <= N; k++) begin
                idx = last_q + MASTERS_WIDTH'(k);
                if (!found && mCycI[idx]) begin
                    found   = 1'b1;
                    owner_d = idx;
                    last_d  = idx;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (TMO == 16'd0 || !sStbO || sAckI || timeout) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            owner_q <= '0;
            last_q  <= '1;
            cnt_q   <= 16'd0;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Scoreboarded bench for wishbone_rr_arbiter: directed scenarios plus
// randomized two-master traffic against a transaction-level model.
module tb_wishbone_rr_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mCycI = '0;
    logic [1:0]  mStbI = '0;
    logic [1:0]  mWeI = '0;
    logic [31:0] mAdrIPacked = '0;
    logic [31:0] mDatIPacked = '0;
    logic [31:0] mDatOPacked;
    logic [1:0]  mAckO;
    logic [1:0]  mErrO;
    logic [1:0]  grant;
    logic        sCycO;
    logic        sStbO;
    logic        sWeO;
    logic [15:0] sAdrO;
    logic [15:0] sDatO;
    logic        sAckI = 1'b0;
    logic [15:0] sDatI = '0;

    wishbone_rr_arbiter #(
        .MASTERS_WIDTH(1),
        .ADDRESS_WIDTH(16),
        .DATA_WIDTH(16),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .mCycI(mCycI), .mStbI(mStbI), .mWeI(mWeI),
        .mAdrIPacked(mAdrIPacked), .mDatIPacked(mDatIPacked),
        .mDatOPacked(mDatOPacked), .mAckO(mAckO), .mErrO(mErrO),
        .grant(grant), .sCycO(sCycO), .sStbO(sStbO), .sWeO(sWeO),
        .sAdrO(sAdrO), .sDatO(sDatO), .sAckI(sAckI), .sDatI(sDatI)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          m;
        logic [15:0] a;
        logic [15:0] d;
        bit          we;
        bit          err;
        logic [15:0] rd;
        int          wt;
    } exp_t;

    exp_t q[$];
    int   order[$];
    int   checks = 0;
    int   failures = 0;
    bit   abort = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_grant"}, 32'(grant), 0);
        chk({nm, "_ack"}, 32'(mAckO), 0);
        chk({nm, "_err"}, 32'(mErrO), 0);
        chk({nm, "_sctl"}, {29'd0, sCycO, sStbO, sWeO}, 0);
        chk({nm, "_sadr"}, 32'(sAdrO), 0);
        chk({nm, "_sdat"}, 32'(sDatO), 0);
    endtask

    // Slave: acks after adr[2:0] wait cycles, read data is the byte-swapped address.
    int s_wait = 0;
    bit s_act = 1'b0;
    bit term_seen = 1'b0;
    always @(negedge clk) begin
        if (sCycO && sStbO) begin
            if (!s_act || term_seen) s_wait = 0;
            else s_wait++;
            s_act = 1'b1;
        end else begin
            s_act = 1'b0;
            s_wait = 0;
        end
        sAckI = s_act && (s_wait == int'(sAdrO[2:0]));
        sDatI = s_act ? {sAdrO[7:0], sAdrO[15:8]} : 16'($urandom);
    end

    // Reference ownership: first requester after the last winner, held while CYC stays up.
    bit       mv = 1'b0;
    int       mo = 0;
    int       ml = 1;
    bit [1:0] cyc_p = '0;
    bit       rst_p = 1'b0;
    logic [1:0] prev_g = '0;
    always @(negedge clk) begin
        #1;
        if (!rst_p) begin
            mv = 1'b0;
            mo = 0;
            ml = 1;
        end else if (!mv || !cyc_p[mo]) begin
            mv = 1'b0;
            for (int k = 1; k <= 2; k++) begin
                if (!mv && cyc_p[(ml + k) % 2]) begin
                    mo = (ml + k) % 2;
                    ml = mo;
                    mv = 1'b1;
                end
            end
        end
        chk("grant", 32'(grant), (mv && rst) ? (32'd1 << mo) : 32'd0);
        if (grant != 2'b00 && grant != prev_g) order.push_back(grant == 2'b10 ? 1 : 0);
        prev_g = grant;
        for (int m = 0; m < 2; m++) begin
            if (mAckO[m] || mErrO[m]) begin
                int idx;
                idx = -1;
                for (int i = 0; i < q.size(); i++)
                    if (idx < 0 && q[i].m == m) idx = i;
                if (idx < 0) begin
                    chk($sformatf("unexpected_term_m%0d", m), {30'd0, mAckO[m], mErrO[m]}, 0);
                end else begin
                    exp_t e;
                    e = q[idx];
                    q.delete(idx);
                    chk("ack_err_both", 32'(mAckO[m] & mErrO[m]), 0);
                    chk("term_kind_err", 32'(mErrO[m]), 32'(e.err));
                    chk("wait_cycles", 32'(s_wait), 32'(e.wt));
                    chk("s_adr", 32'(sAdrO), 32'(e.a));
                    chk("s_we", 32'(sWeO), 32'(e.we));
                    if (e.we) chk("s_dat", 32'(sDatO), 32'(e.d));
                    else if (!e.err) chk("rd_lanes", mDatOPacked, {e.rd, e.rd});
                end
            end
        end
        term_seen = |mAckO || |mErrO;
        cyc_p = mCycI;
        rst_p = rst;
    end

    task automatic session(input int m, input int n, input logic [15:0] a0,
                           input bit we0, input logic [15:0] d0, input bit rnd);
        for (int j = 0; j < n; j++) begin
            exp_t e;
            int cnt;
            logic [15:0] a, d;
            bit w;
            a = a0 + 16'(j * 8);
            d = d0 + 16'(j);
            w = we0;
            if (rnd) begin
                a = 16'($urandom);
                a[2:0] = 3'($urandom_range(0, 6));
                d = 16'($urandom);
                w = 1'($urandom);
            end
            mAdrIPacked[m*16 +: 16] = a;
            mDatIPacked[m*16 +: 16] = d;
            mWeI[m] = w;
            mCycI[m] = 1'b1;
            mStbI[m] = 1'b1;
            e.m = m; e.a = a; e.d = d; e.we = w;
            e.err = (a[2:0] > 3'(TMO));
            e.wt = e.err ? TMO : int'(a[2:0]);
            e.rd = {a[7:0], a[15:8]};
            q.push_back(e);
            cnt = 0;
            do begin
                @(negedge clk);
                #2;
                cnt++;
            end while (!(mAckO[m] || mErrO[m]) && cnt < 200 && !abort);
            if (!abort && cnt >= 200) chk($sformatf("term_timeout_m%0d", m), 1, 0);
            @(posedge clk);
            #1;
            if (abort) break;
        end
        mCycI[m] = 1'b0;
        mStbI[m] = 1'b0;
        mWeI[m] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_order(input string nm, input int exp_o[$]);
        chk({nm, "_len"}, 32'(order.size()), 32'(exp_o.size()));
        for (int i = 0; i < exp_o.size() && i < order.size(); i++)
            chk($sformatf("%s_%0d", nm, i), 32'(order[i]), 32'(exp_o[i]));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        mCycI = 2'b11;
        idle(2);
        @(negedge clk); #3;
        chk_idle("reset");
        mCycI = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #3;
        chk_idle("post_reset");
        idle(1);

        order.delete();
        fork
            begin
                session(0, 1, 16'h0100, 1'b1, 16'h1111, 1'b0);
                idle(1);
                session(0, 1, 16'h0108, 1'b1, 16'h1112, 1'b0);
            end
            begin
                session(1, 1, 16'h0200, 1'b0, 16'h0, 1'b0);
                idle(1);
                session(1, 1, 16'h0208, 1'b0, 16'h0, 1'b0);
            end
        join
        chk_order("contention", '{0, 1, 0, 1});
        idle(2);

        session(1, 1, 16'h4010, 1'b1, 16'h00A5, 1'b0);
        idle(2);

        order.delete();
        fork
            session(0, 3, 16'h0300, 1'b1, 16'h2200, 1'b0);
            begin
                idle(1);
                session(1, 1, 16'h0400, 1'b1, 16'h3300, 1'b0);
            end
        join
        chk_order("cycle_lock", '{0, 1});
        idle(2);

        session(1, 1, 16'h0507, 1'b0, 16'h0, 1'b0);
        idle(1);
        session(1, 1, 16'h0604, 1'b0, 16'h0, 1'b0);
        idle(1);
        session(1, 1, 16'hA500, 1'b0, 16'h0, 1'b0);
        idle(2);

        fork
            session(1, 1, 16'h0707, 1'b1, 16'hBEEF, 1'b0);
            begin
                idle(4);
                rst = 1'b0;
                abort = 1'b1;
                @(negedge clk); #3;
                chk_idle("rst_hold");
                @(negedge clk); #3;
                chk_idle("rst_next");
            end
        join
        q.delete();
        idle(1);
        rst = 1'b1;
        abort = 1'b0;
        idle(1);
        order.delete();
        fork
            session(0, 1, 16'h0800, 1'b0, 16'h0, 1'b0);
            session(1, 1, 16'h0900, 1'b0, 16'h0, 1'b0);
        join
        chk_order("after_reset", '{0, 1});
        idle(2);

        fork
            for (int t = 0; t < 30; t++) begin
                session(0, $urandom_range(1, 3), 16'h0, 1'b0, 16'h0, 1'b1);
                idle($urandom_range(1, 3));
            end
            for (int t = 0; t < 30; t++) begin
                session(1, $urandom_range(1, 3), 16'h0, 1'b0, 16'h0, 1'b1);
                idle($urandom_range(1, 3));
            end
        join
        idle(3);
        chk("scoreboard_empty", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
